wb_load_queue: RTL and testbench

In-order write-back retire queue for the MiniMIPS32 pipeline, sitting between the memory stage and the register file. Memory responses may now arrive several cycles after the access instead of in the same cycle. Every instruction leaving the memory stage enters the queue. Loads wait for their in-order memory response, then get lane extraction with sign/zero extension. Entries retire one per cycle in program order to the register file. A flush kills unretired entries and discards memory responses still owed to killed loads.

---
 rtl/wb_load_queue_pkg.sv | 17 +
 rtl/wb_load_queue_if.sv | 41 ++++
 rtl/wb_load_align.sv | 59 +++++
 rtl/wb_load_queue.sv | 153 +++++++++++++++
 tb/tb_wb_load_queue.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_load_queue_pkg.sv
// Shared constants for the write-back retire queue: byte-count derivation,
// load-lane masks and the memory-result enable flag.
package wb_load_queue_pkg;

    // Loads are honoured; clearing this turns every entry into an ALU result.
    localparam bit MREG_ENABLE = 1'b1;

    // Contiguous byte-enable patterns of each lane size, anchored at lane 0.
    localparam int BYTE_MASK = 1;
    localparam int HALF_MASK = 3;
    localparam int WORD_MASK = 15;

    function automatic int nb_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_load_queue_if.sv
// Memory-stage, data-memory response, retire and hazard-check signals of the
// write-back retire queue.
interface wb_load_queue_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import wb_load_queue_pkg::*;

    localparam int NB = nb_of(DATA_W);

    logic              mem_valid_i;
    logic              mem_ready_o;
    logic              mem_wreg_i;
    logic [REG_AW-1:0] mem_wa_i;
    logic              mem_mreg_i;
    logic [NB-1:0]     mem_dre_i;
    logic              mem_unsign_i;
    logic [DATA_W-1:0] mem_dreg_i;
    logic              dm_valid_i;
    logic [DATA_W-1:0] dm_i;
    logic              flush_i;
    logic              wb_wreg_o;
    logic [REG_AW-1:0] wb_wa_o;
    logic [DATA_W-1:0] wb_wd_o;
    logic              wb_retire_o;
    logic [REG_AW-1:0] chk_ra_i;
    logic              chk_busy_o;

    modport master (
        output mem_valid_i, mem_wreg_i, mem_wa_i, mem_mreg_i, mem_dre_i,
               mem_unsign_i, mem_dreg_i, dm_valid_i, dm_i, flush_i, chk_ra_i,
        input  mem_ready_o, wb_wreg_o, wb_wa_o, wb_wd_o, wb_retire_o, chk_busy_o
    );

    modport slave (
        input  mem_valid_i, mem_wreg_i, mem_wa_i, mem_mreg_i, mem_dre_i,
               mem_unsign_i, mem_dreg_i, dm_valid_i, dm_i, flush_i, chk_ra_i,
        output mem_ready_o, wb_wreg_o, wb_wa_o, wb_wd_o, wb_retire_o, chk_busy_o
    );

endinterface

// File: rtl/wb_load_align.sv
// Load lane extraction: picks the byte/half/word selected by dre, moves it to
// bit 0 and sign- or zero-extends it. Unsupported enable patterns yield 0.
module wb_load_align
    import wb_load_queue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [nb_of(DATA_W)-1:0] dre,
    input  logic                     unsign,
    input  logic [DATA_W-1:0]        dm,
    output logic [DATA_W-1:0]        data
);
    localparam int NB = nb_of(DATA_W);
    localparam int NH = NB / 2;

    logic [NB-1:0]     byte_hit;
    logic [DATA_W-1:0] byte_val [NB];
    logic [NH-1:0]     half_hit;
    logic [DATA_W-1:0] half_val [NH];
    logic [1:0]        word_hit;
    logic [DATA_W-1:0] word_val [2];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign byte_hit[gi] = (dre == (NB'(BYTE_MASK) << gi));
            assign byte_val[gi] = {{(DATA_W-8){~unsign & dm[gi*8+7]}}, dm[gi*8 +: 8]};
        end

        for (gi = 0; gi < NH; gi++) begin : g_half
            assign half_hit[gi] = (dre == (NB'(HALF_MASK) << (2*gi)));
            assign half_val[gi] = {{(DATA_W-16){~unsign & dm[gi*16+15]}}, dm[gi*16 +: 16]};
        end

        // A 32-bit word is only a sub-lane when the bus is 64 bits wide.
        if (DATA_W == 64) begin : g_word
            for (gi = 0; gi < 2; gi++) begin : g_lane
                assign word_hit[gi] = (dre == (NB'(WORD_MASK) << (4*gi)));
                assign word_val[gi] = {{(DATA_W-32){~unsign & dm[gi*32+31]}}, dm[gi*32 +: 32]};
            end
        end else begin : g_no_word
            assign word_hit    = '0;
            assign word_val[0] = '0;
            assign word_val[1] = '0;
        end
    endgenerate

    always_comb begin
        data = '0;
        if (dre == '1) begin
            data = dm;
        end else begin
            for (int i = 0; i < NB; i++) if (byte_hit[i]) data = byte_val[i];
            for (int i = 0; i < NH; i++) if (half_hit[i]) data = half_val[i];
            for (int i = 0; i < 2; i++)  if (word_hit[i]) data = word_val[i];
        end
    end

endmodule

// File: rtl/wb_load_queue.sv
// In-order write-back retire queue: holds instructions leaving the memory stage,
// completes loads from in-order memory responses and retires one per cycle.
module wb_load_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int REG_AW = 5
) (
    input  logic           cpu_clk_50M,
    input  logic           cpu_rst,
    wb_load_queue_if.slave bus
);
    import wb_load_queue_pkg::*;

    localparam int NB = nb_of(DATA_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     head_reg, tail_reg;
    logic [CW-1:0]     count_reg, drop_reg;
    logic [CW-1:0]     count_next, drop_next;
    logic [DEPTH-1:0]  valid_reg, done_reg;
    logic [DEPTH-1:0]  wreg_reg, mreg_reg, unsign_reg;
    logic [REG_AW-1:0] wa_reg   [DEPTH];
    logic [NB-1:0]     dre_reg  [DEPTH];
    logic [DATA_W-1:0] data_reg [DEPTH];

    logic              wb_wreg_reg, wb_retire_reg;
    logic [REG_AW-1:0] wb_wa_reg;
    logic [DATA_W-1:0] wb_wd_reg;

    logic              ready, enq, pop, flush, enq_mreg;
    logic              resp_drop, resp_found, resp_wr;
    logic [PW-1:0]     resp_idx, scan_idx;
    logic [DEPTH-1:0]  pend_after, busy_hit;
    logic [CW-1:0]     pend_cnt;
    logic [DATA_W-1:0] head_aligned, head_wd;

    assign flush     = bus.flush_i;
    // Slots owed to killed loads stay reserved until their responses drain.
    assign ready     = ({1'b0, count_reg} + {1'b0, drop_reg}) < (CW+1)'(DEPTH);
    assign enq       = bus.mem_valid_i & ready & ~flush;
    assign enq_mreg  = bus.mem_mreg_i & MREG_ENABLE;
    assign pop       = valid_reg[head_reg] & done_reg[head_reg];
    assign resp_drop = bus.dm_valid_i & (drop_reg != '0);
    assign resp_wr   = bus.dm_valid_i & (drop_reg == '0) & resp_found;

    // Oldest outstanding load, scanning forward from the head.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = head_reg;
        scan_idx   = head_reg;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_reg + PW'(i);
            if (!resp_found && valid_reg[scan_idx] && mreg_reg[scan_idx] && !done_reg[scan_idx]) begin
                resp_found = 1'b1;
                resp_idx   = scan_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign pend_after[gi] = valid_reg[gi] & mreg_reg[gi] & ~done_reg[gi]
                                  & ~(resp_wr && resp_idx == PW'(gi));
            assign busy_hit[gi]   = valid_reg[gi] & wreg_reg[gi] & (wa_reg[gi] == bus.chk_ra_i);
        end
    endgenerate

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + CW'(pend_after[i]);
    end

    assign count_next = flush ? '0 : count_reg + CW'(enq) - CW'(pop);
    assign drop_next  = drop_reg - CW'(resp_drop) + (flush ? pend_cnt : '0);

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            drop_reg  <= '0;
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            head_reg  <= flush ? '0 : head_reg + PW'(pop);
            tail_reg  <= flush ? '0 : tail_reg + PW'(enq);
            count_reg <= count_next;
            drop_reg  <= drop_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (flush)                             valid_reg[i] <= 1'b0;
                else if (enq && tail_reg == PW'(i))    valid_reg[i] <= 1'b1;
                else if (pop && head_reg == PW'(i))    valid_reg[i] <= 1'b0;
                if (enq && tail_reg == PW'(i))         done_reg[i]  <= ~enq_mreg;
                else if (resp_wr && resp_idx == PW'(i)) done_reg[i] <= 1'b1;
            end
        end
    end

    // Payload is qualified by valid_reg, so it needs no reset.
    always_ff @(posedge cpu_clk_50M) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && tail_reg == PW'(i)) begin
                wreg_reg[i]   <= bus.mem_wreg_i;
                wa_reg[i]     <= bus.mem_wa_i;
                mreg_reg[i]   <= enq_mreg;
                dre_reg[i]    <= bus.mem_dre_i;
                unsign_reg[i] <= bus.mem_unsign_i;
                data_reg[i]   <= bus.mem_dreg_i;
            end else if (resp_wr && resp_idx == PW'(i)) begin
                data_reg[i]   <= bus.dm_i;
            end
        end
    end

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .dre    (dre_reg[head_reg]),
        .unsign (unsign_reg[head_reg]),
        .dm     (data_reg[head_reg]),
        .data   (head_aligned)
    );

    assign head_wd = mreg_reg[head_reg] ? head_aligned : data_reg[head_reg];

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            wb_wreg_reg   <= 1'b0;
            wb_retire_reg <= 1'b0;
            wb_wa_reg     <= '0;
            wb_wd_reg     <= '0;
        end else begin
            wb_wreg_reg   <= pop & wreg_reg[head_reg];
            wb_retire_reg <= pop;
            if (pop) begin
                wb_wa_reg <= wa_reg[head_reg];
                wb_wd_reg <= head_wd;
            end
        end
    end

    assign bus.mem_ready_o = ready;
    assign bus.wb_wreg_o   = wb_wreg_reg;
    assign bus.wb_wa_o     = wb_wa_reg;
    assign bus.wb_wd_o     = wb_wd_reg;
    assign bus.wb_retire_o = wb_retire_reg;
    assign bus.chk_busy_o  = (bus.chk_ra_i != '0) & (|busy_hit);

    // A response must either be owed to a killed load or complete a live one.
    resp_has_target: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
        !(bus.dm_valid_i && drop_reg == '0 && !resp_found));

endmodule

// File: tb/tb_wb_load_queue.sv
// Directed bench for wb_load_queue: expected retires go into a scoreboard that
// a monitor compares against every wb_retire_o pulse.
module tb_wb_load_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int REG_AW = 5;

    typedef struct {
        logic              wreg;
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    wb_load_queue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    wb_load_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit mreg, input bit wreg, input logic [REG_AW-1:0] wa,
                         input logic [3:0] dre, input bit uns, input logic [DATA_W-1:0] dreg,
                         input bit expect_retire, input logic [DATA_W-1:0] exp_wd);
        int waited = 0;
        bus.mem_valid_i  = 1'b1;
        bus.mem_mreg_i   = mreg;
        bus.mem_wreg_i   = wreg;
        bus.mem_wa_i     = wa;
        bus.mem_dre_i    = dre;
        bus.mem_unsign_i = uns;
        bus.mem_dreg_i   = dreg;
        while (!bus.mem_ready_o && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.mem_ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_wait wa=%0d: got ready=0 for 50 cycles, required ready=1", wa);
        end
        if (expect_retire) exp_q.push_back(exp_t'{wreg, wa, exp_wd});
        tick();
        bus.mem_valid_i = 1'b0;
    endtask

    task automatic respond(input logic [DATA_W-1:0] d);
        bus.dm_valid_i = 1'b1;
        bus.dm_i       = d;
        tick();
        bus.dm_valid_i = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && bus.wb_retire_o) begin
            $display("retire wa=%0d wreg=%0b wd=0x%08h", bus.wb_wa_o, bus.wb_wreg_o, bus.wb_wd_o);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL retire_unexpected: got retire wa=%0d, required none", bus.wb_wa_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("retire_wreg", bus.wb_wreg_o, mon_e.wreg);
                check("retire_wa",   bus.wb_wa_o,   mon_e.wa);
                check("retire_wd",   bus.wb_wd_o,   mon_e.wd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "timeout");
    end

    logic [3:0]        lt_dre [9] = '{4'b0100, 4'b0010, 4'b0010, 4'b1100, 4'b0101,
                                      4'b1111, 4'b0011, 4'b1000, 4'b0110};
    logic              lt_uns [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [DATA_W-1:0] lt_exp [9] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                      32'h00000000, 32'h80018000, 32'h00008000, 32'hFFFFFF80,
                                      32'h00000000};

    initial begin
        bus.mem_valid_i  = 1'b0;
        bus.mem_wreg_i   = 1'b0;
        bus.mem_wa_i     = '0;
        bus.mem_mreg_i   = 1'b0;
        bus.mem_dre_i    = '0;
        bus.mem_unsign_i = 1'b0;
        bus.mem_dreg_i   = '0;
        bus.dm_valid_i   = 1'b0;
        bus.dm_i         = '0;
        bus.flush_i      = 1'b0;
        bus.chk_ra_i     = 5'd7;

        // Power-on reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_wreg",   bus.wb_wreg_o,   0);
        check("rst_wa",     bus.wb_wa_o,     0);
        check("rst_wd",     bus.wb_wd_o,     0);
        check("rst_retire", bus.wb_retire_o, 0);
        check("rst_ready",  bus.mem_ready_o, 1);
        check("rst_busy",   bus.chk_busy_o,  0);

        // Non-load latency: visible exactly two edges after issue
        issue(0, 1, 5'd3, 4'b1111, 0, 32'h12345678, 1, 32'h12345678);
        check("nl_early_retire", bus.wb_retire_o, 0);
        tick();
        check("nl_retire", bus.wb_retire_o, 1);
        check("nl_wreg",   bus.wb_wreg_o,   1);
        check("nl_wa",     bus.wb_wa_o,     3);
        check("nl_wd",     bus.wb_wd_o,     32'h12345678);
        issue(0, 0, 5'd6, 4'b1111, 0, 32'h0000DEAD, 1, 32'h0000DEAD);
        tick();
        tick();

        // Byte-lane loads from dm = 0x80018000
        for (int i = 0; i < 9; i++) begin
            issue(1, 1, REG_AW'(8 + i), lt_dre[i], lt_uns[i], 32'h0, 1, lt_exp[i]);
            respond(32'h80018000);
            tick();
            tick();
        end

        // Full queue, then in-order retire with a non-load behind
        issue(1, 1, 5'd10, 4'b1111, 0, 32'h0, 1, 32'h11111111);
        issue(1, 1, 5'd11, 4'b1111, 0, 32'h0, 1, 32'h22222222);
        issue(1, 1, 5'd12, 4'b1111, 0, 32'h0, 1, 32'h33333333);
        issue(1, 1, 5'd13, 4'b1111, 0, 32'h0, 1, 32'h44444444);
        check("full_ready", bus.mem_ready_o, 0);
        respond(32'h11111111);
        check("full_no_retire", bus.wb_retire_o, 0);
        respond(32'h22222222);
        check("order_first_retire", bus.wb_retire_o, 1);
        check("order_first_wa",     bus.wb_wa_o,     10);
        tick();
        check("order_second_retire", bus.wb_retire_o, 1);
        check("order_second_wa",     bus.wb_wa_o,     11);
        issue(0, 1, 5'd14, 4'b1111, 0, 32'h14141414, 1, 32'h14141414);
        respond(32'h33333333);
        respond(32'h44444444);
        for (int i = 0; i < 4; i++) tick();

        // Flush with a done non-load at the head and two pending loads behind
        issue(1, 1, 5'd19, 4'b1111, 0, 32'h0, 1, 32'hA0A0A0A0);
        issue(0, 1, 5'd20, 4'b1111, 0, 32'h20202020, 1, 32'h20202020);
        issue(1, 1, 5'd21, 4'b1111, 0, 32'h0, 0, 32'h0);
        issue(1, 1, 5'd22, 4'b1111, 0, 32'h0, 0, 32'h0);
        respond(32'hA0A0A0A0);
        tick();
        bus.flush_i     = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_mreg_i  = 1'b0;
        bus.mem_wreg_i  = 1'b1;
        bus.mem_wa_i    = 5'd25;
        bus.mem_dreg_i  = 32'h25252525;
        tick();
        bus.flush_i     = 1'b0;
        bus.mem_valid_i = 1'b0;
        check("flush_head_retire", bus.wb_retire_o, 1);
        check("flush_head_wa",     bus.wb_wa_o,     20);
        check("flush_ready",       bus.mem_ready_o, 1);
        issue(1, 1, 5'd23, 4'b1111, 0, 32'h0, 1, 32'hD0D0D0D0);
        check("flush_ready_one", bus.mem_ready_o, 1);
        issue(1, 1, 5'd24, 4'b1111, 0, 32'h0, 1, 32'hE0E0E0E0);
        check("flush_ready_two", bus.mem_ready_o, 0);
        respond(32'hBAD0BAD0);
        check("drop1_ready",     bus.mem_ready_o, 1);
        check("drop1_no_retire", bus.wb_retire_o, 0);
        respond(32'hBAD1BAD1);
        check("drop2_no_retire", bus.wb_retire_o, 0);
        respond(32'hD0D0D0D0);
        respond(32'hE0E0E0E0);
        for (int i = 0; i < 4; i++) tick();

        // Hazard lookup
        issue(1, 1, 5'd7, 4'b1111, 0, 32'h0, 1, 32'h77777777);
        bus.chk_ra_i = 5'd7;
        #1 check("busy_match", bus.chk_busy_o, 1);
        bus.chk_ra_i = 5'd0;
        #1 check("busy_r0", bus.chk_busy_o, 0);
        bus.chk_ra_i = 5'd5;
        #1 check("busy_other", bus.chk_busy_o, 0);
        bus.chk_ra_i = 5'd7;
        respond(32'h77777777);
        check("busy_done_unretired", bus.chk_busy_o, 1);
        tick();
        check("busy_after_retire", bus.chk_busy_o, 0);
        issue(0, 0, 5'd7, 4'b1111, 0, 32'h00000707, 1, 32'h00000707);
        check("busy_no_wreg", bus.chk_busy_o, 0);
        tick();
        tick();

        // Asynchronous reset with three entries queued
        bus.chk_ra_i = 5'd2;
        issue(1, 1, 5'd1, 4'b1111, 0, 32'h0, 0, 32'h0);
        issue(1, 1, 5'd2, 4'b1111, 0, 32'h0, 0, 32'h0);
        issue(0, 1, 5'd3, 4'b1111, 0, 32'h33330000, 0, 32'h0);
        check("pre_rst_busy", bus.chk_busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wreg",   bus.wb_wreg_o,   0);
        check("mid_rst_wa",     bus.wb_wa_o,     0);
        check("mid_rst_wd",     bus.wb_wd_o,     0);
        check("mid_rst_retire", bus.wb_retire_o, 0);
        check("mid_rst_ready",  bus.mem_ready_o, 1);
        check("mid_rst_busy",   bus.chk_busy_o,  0);
        tick();
        rst = 1'b0;
        issue(1, 1, 5'd9, 4'b1111, 0, 32'h0, 1, 32'hCAFEF00D);
        respond(32'hCAFEF00D);
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
